// File: rtl/ddr3_chk_pkg.sv
// Shared constants, command/error encodings and the command decoder for the
// DDR3 command-bus protocol checker.
package ddr3_chk_pkg;

  localparam int unsigned NUM_BANKS = 8;
  localparam int unsigned BA_W      = 3;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned CODE_W    = 4;
  localparam int unsigned ERR_W     = 3;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned TMR_W     = 4;

  typedef enum logic [CODE_W-1:0] {
    CMD_NOP  = 4'd0,
    CMD_ACT  = 4'd1,
    CMD_RD   = 4'd2,
    CMD_WR   = 4'd3,
    CMD_PRE  = 4'd4,
    CMD_PREA = 4'd5,
    CMD_REF  = 4'd6,
    CMD_MRS  = 4'd7,
    CMD_ZQ   = 4'd8
  } cmd_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE     = 3'd0,
    ERR_ACT_OPEN = 3'd1,
    ERR_CLOSED   = 3'd2,
    ERR_TRCD     = 3'd3,
    ERR_TRP      = 3'd4,
    ERR_REF_OPEN = 3'd5
  } err_e;

  typedef struct packed {
    cmd_e              code;
    logic [BA_W-1:0]   ba;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  // rcw = {ras_n, cas_n, we_n}; deselected or clock-disabled cycles are NOPs.
  function automatic cmd_e decode_cmd(input logic cke, input logic cs_n,
                                      input logic [2:0] rcw, input logic a10);
    cmd_e c;
    c = CMD_NOP;
    if (cke && !cs_n) begin
      case (rcw)
        3'b011:  c = CMD_ACT;
        3'b101:  c = CMD_RD;
        3'b100:  c = CMD_WR;
        3'b010:  c = a10 ? CMD_PREA : CMD_PRE;
        3'b001:  c = CMD_REF;
        3'b000:  c = CMD_MRS;
        3'b110:  c = CMD_ZQ;
        default: c = CMD_NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/ddr3_cmd_checker_if.sv
// Command pins in, decoded command / error / statistics out.
interface ddr3_cmd_checker_if;
  import ddr3_chk_pkg::*;

  logic              cke;
  logic              cs_n;
  logic              ras_n;
  logic              cas_n;
  logic              we_n;
  logic [BA_W-1:0]   ba;
  logic [ADDR_W-1:0] addr;
  logic              err_clr;

  logic              cmd_valid;
  logic [CODE_W-1:0] cmd_code;
  logic [BA_W-1:0]   cmd_ba;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_row;
  logic              err_flag;
  logic [ERR_W-1:0]  err_code;
  logic [CNT_W-1:0]  act_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [ADDR_W-1:0] mr0;
  logic [ADDR_W-1:0] mr1;
  logic [ADDR_W-1:0] mr2;
  logic [ADDR_W-1:0] mr3;

  modport master (
    output cke, cs_n, ras_n, cas_n, we_n, ba, addr, err_clr,
    input  cmd_valid, cmd_code, cmd_ba, cmd_addr, cmd_row, err_flag, err_code,
           act_cnt, rd_cnt, wr_cnt, mr0, mr1, mr2, mr3
  );

  modport slave (
    input  cke, cs_n, ras_n, cas_n, we_n, ba, addr, err_clr,
    output cmd_valid, cmd_code, cmd_ba, cmd_addr, cmd_row, err_flag, err_code,
           act_cnt, rd_cnt, wr_cnt, mr0, mr1, mr2, mr3
  );

endinterface

// File: rtl/ddr3_bank_tracker.sv
// One bank's open flag, open row and shared tRCD/tRP down-timer.
module ddr3_bank_tracker
  import ddr3_chk_pkg::*;
#(
  parameter int unsigned TRCD = 6,
  parameter int unsigned TRP  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              act,
  input  logic              close,
  input  logic [ADDR_W-1:0] row_in,
  output logic              open,
  output logic [ADDR_W-1:0] row,
  output logic [TMR_W-1:0]  timer
);

  // The timer means tRCD while open and tRP while closed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open  <= 1'b0;
      row   <= '0;
      timer <= '0;
    end else if (act) begin
      open  <= 1'b1;
      row   <= row_in;
      timer <= TMR_W'(TRCD - 1);
    end else if (close) begin
      open  <= 1'b0;
      timer <= TMR_W'(TRP - 1);
    end else if (timer != '0) begin
      timer <= timer - TMR_W'(1);
    end
  end

endmodule

// File: rtl/ddr3_cmd_checker.sv
// Passive DDR3 command-bus monitor: decodes commands, tracks per-bank state and
// latches the first protocol violation.
module ddr3_cmd_checker
  import ddr3_chk_pkg::*;
#(
  parameter int unsigned TRCD = 6,
  parameter int unsigned TRP  = 6
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  ddr3_cmd_checker_if.slave  bus
);

  cmd_t                  dec_c;
  err_e                  err_c;
  logic [NUM_BANKS-1:0]  bank_sel_c;
  logic [NUM_BANKS-1:0]  act_sel_c;
  logic [NUM_BANKS-1:0]  close_sel_c;
  logic [NUM_BANKS-1:0]  bank_open;
  logic [ADDR_W-1:0]     bank_row   [NUM_BANKS];
  logic [TMR_W-1:0]      bank_timer [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    ddr3_bank_tracker #(.TRCD(TRCD), .TRP(TRP)) u_bank (
      .clk    (sys_clk),
      .rst_n  (sys_rst_n),
      .act    (act_sel_c[b]),
      .close  (close_sel_c[b]),
      .row_in (bus.addr),
      .open   (bank_open[b]),
      .row    (bank_row[b]),
      .timer  (bank_timer[b])
    );
  end

  // Decode and rule check against the bank state as it stood before this edge.
  always_comb begin
    dec_c.code  = decode_cmd(bus.cke, bus.cs_n, {bus.ras_n, bus.cas_n, bus.we_n},
                             bus.addr[10]);
    dec_c.ba    = bus.ba;
    dec_c.addr  = bus.addr;
    bank_sel_c  = NUM_BANKS'(1) << bus.ba;
    act_sel_c   = '0;
    close_sel_c = '0;
    err_c       = ERR_NONE;
    case (dec_c.code)
      CMD_ACT: begin
        act_sel_c = bank_sel_c;
        if (bank_open[dec_c.ba])             err_c = ERR_ACT_OPEN;
        else if (bank_timer[dec_c.ba] != '0) err_c = ERR_TRP;
      end
      CMD_RD, CMD_WR: begin
        if (!bank_open[dec_c.ba])            err_c = ERR_CLOSED;
        else if (bank_timer[dec_c.ba] != '0) err_c = ERR_TRCD;
        if (dec_c.addr[10]) close_sel_c = bank_sel_c;
      end
      CMD_PRE:  close_sel_c = bank_sel_c;
      CMD_PREA: close_sel_c = '1;
      CMD_REF:  if (|bank_open) err_c = ERR_REF_OPEN;
      default:  ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bus.cmd_valid <= 1'b0;
      bus.cmd_code  <= '0;
      bus.cmd_ba    <= '0;
      bus.cmd_addr  <= '0;
      bus.cmd_row   <= '0;
      bus.err_flag  <= 1'b0;
      bus.err_code  <= '0;
      bus.act_cnt   <= '0;
      bus.rd_cnt    <= '0;
      bus.wr_cnt    <= '0;
      bus.mr0       <= '0;
      bus.mr1       <= '0;
      bus.mr2       <= '0;
      bus.mr3       <= '0;
    end else begin
      bus.cmd_valid <= (dec_c.code != CMD_NOP);
      bus.cmd_code  <= dec_c.code;
      if (dec_c.code != CMD_NOP) begin
        bus.cmd_ba   <= dec_c.ba;
        bus.cmd_addr <= dec_c.addr;
        bus.cmd_row  <= bank_row[dec_c.ba];
      end

      // First violation sticks; a violation coinciding with err_clr replaces it.
      if (err_c != ERR_NONE) begin
        if (bus.err_clr || !bus.err_flag) begin
          bus.err_flag <= 1'b1;
          bus.err_code <= err_c;
        end
      end else if (bus.err_clr) begin
        bus.err_flag <= 1'b0;
        bus.err_code <= '0;
      end

      if (dec_c.code == CMD_ACT && bus.act_cnt != '1) bus.act_cnt <= bus.act_cnt + CNT_W'(1);
      if (dec_c.code == CMD_RD  && bus.rd_cnt  != '1) bus.rd_cnt  <= bus.rd_cnt  + CNT_W'(1);
      if (dec_c.code == CMD_WR  && bus.wr_cnt  != '1) bus.wr_cnt  <= bus.wr_cnt  + CNT_W'(1);

      if (dec_c.code == CMD_MRS) begin
        case (dec_c.ba[1:0])
          2'd0:    bus.mr0 <= dec_c.addr;
          2'd1:    bus.mr1 <= dec_c.addr;
          2'd2:    bus.mr2 <= dec_c.addr;
          default: bus.mr3 <= dec_c.addr;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_checker.sv
// Self-checking bench for ddr3_cmd_checker: decoded-command scoreboard plus
// per-scenario checks of error latching, timing rules and counters.
module tb_ddr3_cmd_checker;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr3_cmd_checker_if bus();

  ddr3_cmd_checker #(.TRCD(6), .TRP(6)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus.slave)
  );

  typedef struct {
    logic        valid;
    logic [3:0]  code;
    logic [2:0]  ba;
    logic [15:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic deselect();
    bus.cke = 1'b1; bus.cs_n = 1'b1;
    bus.ras_n = 1'b1; bus.cas_n = 1'b1; bus.we_n = 1'b1;
  endtask

  // Drive one command at a negedge, record its expected decode, return at the next negedge.
  task automatic issue(input logic [3:0] code, input logic [2:0] ba, input logic [15:0] addr);
    logic [2:0] rcw;
    exp_t e;
    case (code)
      4'd1: rcw = 3'b011;
      4'd2: rcw = 3'b101;
      4'd3: rcw = 3'b100;
      4'd4: begin rcw = 3'b010; addr[10] = 1'b0; end
      4'd5: begin rcw = 3'b010; addr[10] = 1'b1; end
      4'd6: rcw = 3'b001;
      4'd7: rcw = 3'b000;
      4'd8: rcw = 3'b110;
      default: rcw = 3'b111;
    endcase
    bus.cke = 1'b1; bus.cs_n = 1'b0;
    {bus.ras_n, bus.cas_n, bus.we_n} = rcw;
    bus.ba = ba; bus.addr = addr;
    e.valid = (code != 4'd0); e.code = code; e.ba = ba; e.addr = addr;
    sb_q.push_back(e);
    @(negedge clk);
    deselect();
  endtask

  // ACT pin pattern with cke or cs_n masking it: must decode as NOP.
  task automatic issue_masked(input logic cke_v, input logic cs_v);
    exp_t e;
    bus.cke = cke_v; bus.cs_n = cs_v;
    {bus.ras_n, bus.cas_n, bus.we_n} = 3'b011;
    bus.ba = 3'd6; bus.addr = 16'h5555;
    e.valid = 1'b0; e.code = 4'd0; e.ba = 3'd0; e.addr = 16'h0;
    sb_q.push_back(e);
    @(negedge clk);
    deselect();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    deselect();
    bus.err_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic sb_monitor();
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if (bus.cmd_valid !== e.valid || bus.cmd_code !== e.code) begin
          errors++;
          $display("FAIL sb_cmd: valid=%0b code=%0d, required valid=%0b code=%0d",
                   bus.cmd_valid, bus.cmd_code, e.valid, e.code);
        end
        if (e.valid) begin
          checks++;
          if (bus.cmd_ba !== e.ba || bus.cmd_addr !== e.addr) begin
            errors++;
            $display("FAIL sb_payload: ba=%0d addr=%h, required ba=%0d addr=%h",
                     bus.cmd_ba, bus.cmd_addr, e.ba, e.addr);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.cmd_valid !== 1'b0 || bus.err_flag !== 1'b0 || bus.act_cnt !== 16'h0 || bus.mr0 !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b flag=%0b act=%h mr0=%h, required all 0",
               bus.cmd_valid, bus.err_flag, bus.act_cnt, bus.mr0);
    end
  endtask

  task automatic test_decode();
    do_reset();
    issue(4'd7, 3'd7, 16'h0ABC);
    checks++;
    if (bus.mr3 !== 16'h0ABC) begin errors++; $display("FAIL mrs_ba2_ignored: mr3=%h required 0abc", bus.mr3); end
    issue(4'd8, 3'd0, 16'h0400);
    issue(4'd6, 3'd0, 16'h0000);
    issue(4'd1, 3'd6, 16'h00F0);
    issue_masked(1'b1, 1'b1);
    issue_masked(1'b0, 1'b0);
    checks++;
    if (bus.act_cnt !== 16'd1) begin errors++; $display("FAIL masked_act: act_cnt=%0d required 1", bus.act_cnt); end
    issue(4'd4, 3'd4, 16'h0000);
    issue(4'd5, 3'd0, 16'h0000);
    checks++;
    if (bus.err_flag !== 1'b0) begin errors++; $display("FAIL pre_closed_legal: err_flag=%0b required 0", bus.err_flag); end
  endtask

  task automatic test_act_rd();
    do_reset();
    issue(4'd1, 3'd2, 16'h1234);
    idle(6);
    issue(4'd2, 3'd2, 16'h0010);
    checks++;
    if (bus.err_flag !== 1'b0 || bus.act_cnt !== 16'd1 || bus.rd_cnt !== 16'd1) begin
      errors++;
      $display("FAIL act_rd: flag=%0b act=%0d rd=%0d, required 0/1/1", bus.err_flag, bus.act_cnt, bus.rd_cnt);
    end
    checks++;
    if (bus.cmd_row !== 16'h1234) begin errors++; $display("FAIL open_row: cmd_row=%h required 1234", bus.cmd_row); end
  endtask

  task automatic test_trcd();
    do_reset();
    issue(4'd1, 3'd0, 16'h0001);
    idle(1);
    issue(4'd2, 3'd0, 16'h0000);
    checks++;
    if (bus.err_flag !== 1'b1 || bus.err_code !== 3'd3) begin
      errors++; $display("FAIL trcd_early: flag=%0b code=%0d required 1/3", bus.err_flag, bus.err_code);
    end
    do_reset();
    issue(4'd1, 3'd3, 16'h0002);
    idle(5);
    issue(4'd3, 3'd3, 16'h0000);
    checks++;
    if (bus.err_flag !== 1'b0) begin errors++; $display("FAIL trcd_exact: err_flag=%0b required 0", bus.err_flag); end
    issue(4'd1, 3'd4, 16'h0003);
    idle(4);
    issue(4'd2, 3'd4, 16'h0000);
    checks++;
    if (bus.err_code !== 3'd3) begin errors++; $display("FAIL trcd_one_short: err_code=%0d required 3", bus.err_code); end
  endtask

  task automatic test_closed();
    do_reset();
    issue(4'd2, 3'd5, 16'h0000);
    checks++;
    if (bus.err_code !== 3'd2) begin errors++; $display("FAIL rd_closed: err_code=%0d required 2", bus.err_code); end
    issue(4'd1, 3'd5, 16'h0100);
    issue(4'd1, 3'd5, 16'h0100);
    checks++;
    if (bus.err_flag !== 1'b1 || bus.err_code !== 3'd2 || bus.act_cnt !== 16'd2) begin
      errors++; $display("FAIL first_err_sticky: flag=%0b code=%0d act=%0d required 1/2/2", bus.err_flag, bus.err_code, bus.act_cnt);
    end
  endtask

  task automatic test_ref_clr();
    do_reset();
    issue(4'd1, 3'd1, 16'h0000);
    issue(4'd6, 3'd0, 16'h0000);
    checks++;
    if (bus.err_code !== 3'd5) begin errors++; $display("FAIL ref_open: err_code=%0d required 5", bus.err_code); end
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    checks++;
    if (bus.err_flag !== 1'b0 || bus.err_code !== 3'd0) begin
      errors++; $display("FAIL err_clr: flag=%0b code=%0d required 0/0", bus.err_flag, bus.err_code);
    end
    issue(4'd1, 3'd1, 16'h0000);
    bus.err_clr = 1'b1;
    issue(4'd6, 3'd0, 16'h0000);
    bus.err_clr = 1'b0;
    checks++;
    if (bus.err_flag !== 1'b1 || bus.err_code !== 3'd5) begin
      errors++; $display("FAIL clr_vs_violation: flag=%0b code=%0d required 1/5", bus.err_flag, bus.err_code);
    end
  endtask

  task automatic test_trp_mrs();
    do_reset();
    issue(4'd1, 3'd3, 16'h0000);
    idle(6);
    issue(4'd4, 3'd3, 16'h0000);
    issue(4'd1, 3'd3, 16'h0000);
    checks++;
    if (bus.err_code !== 3'd4) begin errors++; $display("FAIL trp_early: err_code=%0d required 4", bus.err_code); end
    issue(4'd7, 3'd2, 16'h0018);
    checks++;
    if (bus.mr2 !== 16'h0018) begin errors++; $display("FAIL mrs_mr2: mr2=%h required 0018", bus.mr2); end
    do_reset();
    issue(4'd5, 3'd0, 16'h0000);
    idle(5);
    issue(4'd1, 3'd6, 16'h0000);
    checks++;
    if (bus.err_flag !== 1'b0) begin errors++; $display("FAIL trp_exact: err_flag=%0b required 0", bus.err_flag); end
  endtask

  task automatic test_autopre();
    do_reset();
    issue(4'd1, 3'd7, 16'h00AA);
    idle(6);
    issue(4'd2, 3'd7, 16'h0400);
    checks++;
    if (bus.err_flag !== 1'b0) begin errors++; $display("FAIL rda_legal: err_flag=%0b required 0", bus.err_flag); end
    issue(4'd3, 3'd7, 16'h0000);
    checks++;
    if (bus.err_code !== 3'd2 || bus.wr_cnt !== 16'd1) begin
      errors++; $display("FAIL after_autopre: code=%0d wr=%0d required 2/1", bus.err_code, bus.wr_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(4'd1, 3'd0, 16'h0000);
    idle(6);
    issue(4'd2, 3'd1, 16'h0000);
    issue(4'd7, 3'd1, 16'hBEEF);
    for (int i = 0; i < 70000; i++) begin
      issue(4'd3, 3'd0, 16'h0008);
      if (i == 65533) begin
        checks++;
        if (bus.wr_cnt !== 16'hFFFE) begin errors++; $display("FAIL wr_cnt_pre_sat: wr_cnt=%h required fffe", bus.wr_cnt); end
      end
    end
    checks++;
    if (bus.wr_cnt !== 16'hFFFF || bus.err_code !== 3'd2 || bus.act_cnt !== 16'd1) begin
      errors++; $display("FAIL wr_sat: wr=%h code=%0d act=%0d required ffff/2/1", bus.wr_cnt, bus.err_code, bus.act_cnt);
    end
    // Reset lands between edges while a WR is on the pins.
    bus.cke = 1'b1; bus.cs_n = 1'b0;
    {bus.ras_n, bus.cas_n, bus.we_n} = 3'b100;
    bus.ba = 3'd0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.cmd_valid !== 1'b0 || bus.cmd_code !== 4'd0 || bus.cmd_ba !== 3'd0 || bus.cmd_addr !== 16'h0 ||
        bus.cmd_row !== 16'h0 || bus.err_flag !== 1'b0 || bus.err_code !== 3'd0 || bus.act_cnt !== 16'h0 ||
        bus.rd_cnt !== 16'h0 || bus.wr_cnt !== 16'h0 || bus.mr0 !== 16'h0 || bus.mr1 !== 16'h0 ||
        bus.mr2 !== 16'h0 || bus.mr3 !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: valid=%0b code=%0d flag=%0b ecode=%0d wr=%h rd=%h mr1=%h, required all 0",
               bus.cmd_valid, bus.cmd_code, bus.err_flag, bus.err_code, bus.wr_cnt, bus.rd_cnt, bus.mr1);
    end
    @(negedge clk);
    deselect();
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'd2, 3'd0, 16'h0000);
    checks++;
    if (bus.err_code !== 3'd2 || bus.rd_cnt !== 16'd1 || bus.wr_cnt !== 16'd0) begin
      errors++; $display("FAIL post_reset_closed: code=%0d rd=%0d wr=%0d required 2/1/0", bus.err_code, bus.rd_cnt, bus.wr_cnt);
    end
  endtask

  initial begin
    deselect();
    bus.err_clr = 1'b0;
    bus.ba      = 3'd0;
    bus.addr    = 16'h0;
    fork
      sb_monitor();
    join_none
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_decode();
    test_act_rd();
    test_trcd();
    test_closed();
    test_ref_clr();
    test_trp_mrs();
    test_autopre();
    test_back_to_back();
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
